// File: rtl/descriptor_tx_unpack.sv
// rtl/descriptor_tx_unpack.sv - TTI TX descriptor engine with internal word-to-byte unpacker
// Optional: DESCRIPTOR_TX_UNPACK_MSB_FIRST_EN selects MSB-first byte order within each data word.
module descriptor_tx_unpack #(
    parameter int DescDataWidth = 32,
    parameter int DataWidth     = 32,
    parameter int LenWidth      = 16,
    parameter int DepthWidth    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     desc_rvalid_i,
    output logic                     desc_rready_o,
    input  logic [DescDataWidth-1:0] desc_rdata_i,
    input  logic                     data_rvalid_i,
    output logic                     data_rready_o,
    input  logic [DataWidth-1:0]     data_rdata_i,
    input  logic [DepthWidth-1:0]    data_depth_i,
    input  logic                     tx_start_i,
    input  logic                     tx_abort_i,
    output logic                     tx_desc_avail_o,
    output logic [7:0]               tx_byte_o,
    output logic                     tx_byte_valid_o,
    input  logic                     tx_byte_ready_i,
    output logic                     tx_byte_last_o,
    output logic                     tx_end_o,
    output logic                     tx_aborted_o,
    output logic [LenWidth-1:0]      tx_count_o
);

    localparam int Bpw      = DataWidth / 8;
    localparam int IdxWidth = (Bpw > 1) ? $clog2(Bpw) : 1;
    localparam int CmpWidth = (DepthWidth > LenWidth) ? DepthWidth : LenWidth;

    localparam logic [LenWidth-1:0] BpwLen  = LenWidth'(Bpw);
    localparam logic [LenWidth-1:0] OneLen  = LenWidth'(1);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Bpw - 1);
    localparam logic [IdxWidth-1:0] OneIdx  = IdxWidth'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SEND  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [LenWidth-1:0]  words_left_q;
    logic [LenWidth-1:0]  remaining_q;
    logic [LenWidth-1:0]  count_q;
    logic [IdxWidth-1:0]  byte_idx_q;
    logic [DataWidth-1:0] word_q;
    logic                 word_held_q;
    logic                 end_q;
    logic                 aborted_q;

    logic [LenWidth-1:0]  desc_len;
    logic [LenWidth-1:0]  desc_words;
    logic                 len_rem_nz;
    logic                 depth_ok;
    logic                 byte_hs;
    logic                 last_hs;
    logic                 word_release;
    logic                 idle_pop;
    logic                 send_load;
    logic                 flush_pop;
    logic                 flush_done;
    logic                 wait_abort;
    logic                 send_abort;
    logic [DataWidth-1:0] word_shifted;
    logic [7:0]           byte_sel;
    logic                 unused_desc;

    assign unused_desc = ^desc_rdata_i;

    // ceil(len/BPW) without widening: a non-zero remainder adds one word
    assign desc_len   = desc_rdata_i[LenWidth-1:0];
    assign len_rem_nz = (desc_len % BpwLen) != '0;
    assign desc_words = (desc_len / BpwLen) + (len_rem_nz ? OneLen : '0);

    assign depth_ok = CmpWidth'(data_depth_i) >= CmpWidth'(words_left_q);

    assign byte_hs      = (state_q == S_SEND) & word_held_q & tx_byte_ready_i;
    assign last_hs      = byte_hs & (remaining_q == OneLen);
    assign word_release = byte_hs & ((byte_idx_q == LastIdx) | (remaining_q == OneLen));

    assign idle_pop   = (state_q == S_IDLE) & tx_start_i & desc_rvalid_i & ~tx_abort_i & ~rst_i;
    assign wait_abort = (state_q == S_WAIT) & tx_abort_i;
    assign send_abort = (state_q == S_SEND) & tx_abort_i & ~last_hs;

    // A fresh word may replace the current one in the cycle its last byte goes out
    assign send_load = (state_q == S_SEND) & data_rvalid_i & (words_left_q != '0) & ~tx_abort_i
                     & (~word_held_q | (word_release & ~last_hs)) & ~rst_i;
    assign flush_pop  = (state_q == S_FLUSH) & data_rvalid_i & (words_left_q != '0) & ~rst_i;
    assign flush_done = (state_q == S_FLUSH) & ((words_left_q == '0) | ~data_rvalid_i);

`ifdef DESCRIPTOR_TX_UNPACK_MSB_FIRST_EN
    assign word_shifted = word_q << {byte_idx_q, 3'b000};
    assign byte_sel     = word_shifted[DataWidth-1 -: 8];
`else
    assign word_shifted = word_q >> {byte_idx_q, 3'b000};
    assign byte_sel     = word_shifted[7:0];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (idle_pop && (desc_len != '0)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_abort_i) begin
                    state_d = S_IDLE;
                end else if (depth_ok) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (last_hs) begin
                    state_d = S_IDLE;
                end else if (tx_abort_i) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        desc_rready_o   = idle_pop;
        data_rready_o   = send_load | flush_pop;
        tx_byte_valid_o = word_held_q;
        tx_byte_last_o  = word_held_q & (remaining_q == OneLen);
        tx_byte_o       = byte_sel;
        tx_desc_avail_o = desc_rvalid_i;
        tx_end_o        = end_q;
        tx_aborted_o    = aborted_q;
        tx_count_o      = count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            words_left_q <= '0;
            remaining_q  <= '0;
            count_q      <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            word_held_q  <= 1'b0;
            end_q        <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            end_q     <= (idle_pop & (desc_len == '0)) | wait_abort | last_hs | flush_done;
            aborted_q <= wait_abort | flush_done;

            if (idle_pop) begin
                words_left_q <= desc_words;
                remaining_q  <= desc_len;
                count_q      <= '0;
            end

            if (send_load || flush_pop) begin
                words_left_q <= words_left_q - OneLen;
            end

            if (byte_hs) begin
                remaining_q <= remaining_q - OneLen;
                count_q     <= count_q + OneLen;
            end

            if (send_load) begin
                word_q      <= data_rdata_i;
                word_held_q <= 1'b1;
                byte_idx_q  <= '0;
            end else if (word_release || send_abort || (state_q != S_SEND)) begin
                word_held_q <= 1'b0;
            end else if (byte_hs) begin
                byte_idx_q <= byte_idx_q + OneIdx;
            end
        end
    end

endmodule

// File: tb/tb_descriptor_tx_unpack.sv
// tb/tb_descriptor_tx_unpack.sv - self-checking bench for descriptor_tx_unpack (DataWidth=32)
module tb_descriptor_tx_unpack;

    localparam int Bpw = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        desc_rvalid_i = 1'b0;
    logic        desc_rready_o;
    logic [31:0] desc_rdata_i = '0;
    logic        data_rvalid_i = 1'b0;
    logic        data_rready_o;
    logic [31:0] data_rdata_i = '0;
    logic [15:0] data_depth_i = '0;
    logic        tx_start_i = 1'b0;
    logic        tx_abort_i = 1'b0;
    logic        tx_desc_avail_o;
    logic [7:0]  tx_byte_o;
    logic        tx_byte_valid_o;
    logic        tx_byte_ready_i = 1'b1;
    logic        tx_byte_last_o;
    logic        tx_end_o;
    logic        tx_aborted_o;
    logic [15:0] tx_count_o;

    descriptor_tx_unpack dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .desc_rvalid_i(desc_rvalid_i), .desc_rready_o(desc_rready_o), .desc_rdata_i(desc_rdata_i),
        .data_rvalid_i(data_rvalid_i), .data_rready_o(data_rready_o), .data_rdata_i(data_rdata_i),
        .data_depth_i(data_depth_i), .tx_start_i(tx_start_i), .tx_abort_i(tx_abort_i),
        .tx_desc_avail_o(tx_desc_avail_o), .tx_byte_o(tx_byte_o), .tx_byte_valid_o(tx_byte_valid_o),
        .tx_byte_ready_i(tx_byte_ready_i), .tx_byte_last_o(tx_byte_last_o), .tx_end_o(tx_end_o),
        .tx_aborted_o(tx_aborted_o), .tx_count_o(tx_count_o)
    );

    always #5 clk_i = ~clk_i;

    // queue models and monitor state
    logic [31:0] dq[$];
    logic [31:0] wq[$];
    logic [7:0]  got_bytes[$];
    logic        got_last[$];
    int          depth_force = -1;
    bit          rand_ready = 1'b0;
    int          n_desc_pop, n_data_pop, n_end, n_abort, n_abort_alone, n_valid;
    int          tests_run = 0;
    int          fails = 0;

    task automatic drive();
        desc_rvalid_i = (dq.size() > 0);
        desc_rdata_i  = (dq.size() > 0) ? dq[0] : 32'h0;
        data_rvalid_i = (wq.size() > 0);
        data_rdata_i  = (wq.size() > 0) ? wq[0] : 32'h0;
        data_depth_i  = (depth_force >= 0) ? 16'(depth_force) : 16'(wq.size());
    endtask

    task automatic clear_mon();
        got_bytes.delete();
        got_last.delete();
        n_desc_pop = 0; n_data_pop = 0; n_end = 0; n_abort = 0; n_abort_alone = 0; n_valid = 0;
    endtask

    task automatic tick();
        bit p_desc, p_data;
        @(negedge clk_i);
        p_desc = desc_rready_o;
        p_data = data_rready_o;
        if (tx_byte_valid_o) n_valid++;
        if (tx_byte_valid_o && tx_byte_ready_i) begin
            got_bytes.push_back(tx_byte_o);
            got_last.push_back(tx_byte_last_o);
        end
        if (tx_end_o) n_end++;
        if (tx_aborted_o) n_abort++;
        if (tx_aborted_o && !tx_end_o) n_abort_alone++;
        @(posedge clk_i);
        #1;
        if (p_desc && dq.size() > 0) begin void'(dq.pop_front()); n_desc_pop++; end
        if (p_data && wq.size() > 0) begin void'(wq.pop_front()); n_data_pop++; end
        if (rand_ready) tx_byte_ready_i = 1'($urandom_range(0, 1));
        drive();
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] w, input int k);
`ifdef DESCRIPTOR_TX_UNPACK_MSB_FIRST_EN
        return w[8*(Bpw-1-k) +: 8];
`else
        return w[8*k +: 8];
`endif
    endfunction

    // Runs one descriptor whose data words are already in wq; checks stream against the model
    task automatic run_xfer(input string name, input int len);
        logic [7:0] exp_bytes[$];
        int nwords, bad, last_bad;
        nwords = (len + Bpw - 1) / Bpw;
        for (int i = 0; i < len; i++) exp_bytes.push_back(ref_byte(wq[i / Bpw], i % Bpw));
        clear_mon();
        dq.push_back(32'(len));
        drive();
        tx_start_i = 1'b1;
        for (int c = 0; c < 3000 && n_end == 0; c++) begin
            tick();
            if (n_desc_pop > 0) tx_start_i = 1'b0;
        end
        tx_start_i = 1'b0;
        tick();
        tick();
        bad = 0;
        last_bad = 0;
        for (int i = 0; i < got_bytes.size() && i < len; i++) begin
            if (got_bytes[i] !== exp_bytes[i]) bad++;
            if (got_last[i] !== (i == len - 1)) last_bad++;
        end
        tests_run++;
        if (n_end !== 1) begin fails++; $display("FAIL %s end_cycles got %0d want 1", name, n_end); end
        tests_run++;
        if (got_bytes.size() !== len || bad != 0)
            begin fails++; $display("FAIL %s bytes got %0d (%0d wrong) want %0d", name, got_bytes.size(), bad, len); end
        tests_run++;
        if (last_bad != 0) begin fails++; $display("FAIL %s last_flag wrong on %0d bytes want 0", name, last_bad); end
        tests_run++;
        if (n_data_pop !== nwords) begin fails++; $display("FAIL %s data_pops got %0d want %0d", name, n_data_pop, nwords); end
        tests_run++;
        if (n_abort !== 0) begin fails++; $display("FAIL %s aborted got %0d want 0", name, n_abort); end
        tests_run++;
        if (tx_count_o !== 16'(len)) begin fails++; $display("FAIL %s count got %0d want %0d", name, tx_count_o, len); end
    endtask

    task automatic test_reset();
        dq.push_back(32'd3);
        tx_start_i = 1'b1;
        rst_i = 1'b1;
        drive();
        tick();
        tick();
        tests_run++;
        if (desc_rready_o !== 1'b0) begin fails++; $display("FAIL reset_desc_rready got %b want 0", desc_rready_o); end
        tests_run++;
        if (tx_desc_avail_o !== 1'b1) begin fails++; $display("FAIL reset_desc_avail got %b want 1", tx_desc_avail_o); end
        tests_run++;
        if ({data_rready_o, tx_byte_valid_o, tx_byte_last_o, tx_end_o, tx_aborted_o, tx_byte_o, tx_count_o} !== '0)
            begin fails++; $display("FAIL reset_outputs got %0h want 0",
                {data_rready_o, tx_byte_valid_o, tx_byte_last_o, tx_end_o, tx_aborted_o, tx_byte_o, tx_count_o}); end
        dq.delete();
        tx_start_i = 1'b0;
        rst_i = 1'b0;
        drive();
        tick();
        tests_run++;
        if (tx_desc_avail_o !== 1'b0) begin fails++; $display("FAIL reset_desc_avail_empty got %b want 0", tx_desc_avail_o); end
    endtask

    task automatic test_basic();
        wq.push_back(32'h44332211);
        wq.push_back(32'h000000AA);
        tx_byte_ready_i = 1'b1;
        run_xfer("basic_len5", 5);
    endtask

    task automatic test_depth_wait();
        int lat;
        for (int i = 0; i < 2; i++) wq.push_back($urandom);
        depth_force = 1;
        clear_mon();
        dq.push_back(32'd8);
        drive();
        tx_start_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (n_desc_pop > 0) tx_start_i = 1'b0;
        end
        tests_run++;
        if (n_valid !== 0 || n_data_pop !== 0)
            begin fails++; $display("FAIL depth_hold valid_cycles %0d pops %0d want 0 0", n_valid, n_data_pop); end
        depth_force = -1;
        drive();
        lat = 0;
        for (int c = 0; c < 20 && n_valid == 0; c++) begin tick(); lat++; end
        tests_run++;
        if (lat !== 3) begin fails++; $display("FAIL depth_latency got %0d want 3", lat); end
        for (int c = 0; c < 100 && n_end == 0; c++) tick();
        tests_run++;
        if (got_bytes.size() !== 8 || tx_count_o !== 16'd8)
            begin fails++; $display("FAIL depth_bytes got %0d/%0d want 8", got_bytes.size(), tx_count_o); end
        tick();
    endtask

    task automatic test_abort_send();
        for (int i = 0; i < 3; i++) wq.push_back($urandom);
        clear_mon();
        dq.push_back(32'd12);
        drive();
        tx_start_i = 1'b1;
        tx_byte_ready_i = 1'b1;
        for (int c = 0; c < 100 && got_bytes.size() < 2; c++) begin
            tick();
            if (n_desc_pop > 0) tx_start_i = 1'b0;
        end
        tx_byte_ready_i = 1'b0;
        tx_abort_i = 1'b1;
        tick();
        tx_abort_i = 1'b0;
        tx_byte_ready_i = 1'b1;
        for (int c = 0; c < 100 && n_end == 0; c++) tick();
        tick();
        tests_run++;
        if (n_data_pop !== 3) begin fails++; $display("FAIL abort_pops got %0d want 3", n_data_pop); end
        tests_run++;
        if (n_end !== 1 || n_abort !== 1 || n_abort_alone !== 0)
            begin fails++; $display("FAIL abort_pulses end %0d aborted %0d lone %0d want 1 1 0", n_end, n_abort, n_abort_alone); end
        tests_run++;
        if (tx_count_o !== 16'd2) begin fails++; $display("FAIL abort_count got %0d want 2", tx_count_o); end
        for (int i = 0; i < 2; i++) wq.push_back($urandom);
        run_xfer("after_abort", 7);
    endtask

    task automatic test_zero_len();
        clear_mon();
        dq.push_back(32'h00AB_0000);
        drive();
        tx_start_i = 1'b1;
        for (int c = 0; c < 20 && n_desc_pop == 0; c++) tick();
        tx_start_i = 1'b0;
        tick();
        tests_run++;
        if (n_desc_pop !== 1 || n_end !== 1)
            begin fails++; $display("FAIL zero_len pops %0d end %0d want 1 1", n_desc_pop, n_end); end
        tick();
        tick();
        tests_run++;
        if (n_data_pop !== 0 || n_abort !== 0 || n_end !== 1)
            begin fails++; $display("FAIL zero_len_side data %0d aborted %0d end %0d want 0 0 1", n_data_pop, n_abort, n_end); end
    endtask

    task automatic test_hold_and_wait_abort();
        int unstable;
        wq.push_back(32'h44332211);
        wq.push_back(32'h000000AA);
        clear_mon();
        dq.push_back(32'd5);
        drive();
        tx_start_i = 1'b1;
        tx_byte_ready_i = 1'b1;
        for (int c = 0; c < 100 && got_bytes.size() < 2; c++) begin
            tick();
            if (n_desc_pop > 0) tx_start_i = 1'b0;
        end
        tx_byte_ready_i = 1'b0;
        unstable = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (tx_byte_valid_o !== 1'b1 || tx_byte_o !== ref_byte(32'h44332211, 2)) unstable++;
        end
        tests_run++;
        if (unstable != 0 || n_data_pop !== 1)
            begin fails++; $display("FAIL hold_stable bad %0d pops %0d want 0 1", unstable, n_data_pop); end
        tx_byte_ready_i = 1'b1;
        for (int c = 0; c < 100 && n_end == 0; c++) tick();
        tests_run++;
        if (got_bytes.size() !== 5 || n_data_pop !== 2 || tx_count_o !== 16'd5)
            begin fails++; $display("FAIL hold_finish bytes %0d pops %0d count %0d want 5 2 5",
                got_bytes.size(), n_data_pop, tx_count_o); end
        tick();
        clear_mon();
        dq.push_back(32'd8);
        drive();
        tx_start_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (n_desc_pop > 0) tx_start_i = 1'b0;
        end
        tx_abort_i = 1'b1;
        tick();
        tx_abort_i = 1'b0;
        tick();
        tick();
        tests_run++;
        if (n_data_pop !== 0 || n_end !== 1 || n_abort !== 1 || n_abort_alone !== 0)
            begin fails++; $display("FAIL wait_abort pops %0d end %0d aborted %0d want 0 1 1", n_data_pop, n_end, n_abort); end
    endtask

    task automatic test_reset_mid_send();
        wq.push_back(32'h55667788);
        wq.push_back(32'h99AABBCC);
        clear_mon();
        dq.push_back(32'd6);
        drive();
        tx_start_i = 1'b1;
        tx_byte_ready_i = 1'b1;
        for (int c = 0; c < 100 && got_bytes.size() < 2; c++) begin
            tick();
            if (n_desc_pop > 0) tx_start_i = 1'b0;
        end
        rst_i = 1'b1;
        tick();
        tests_run++;
        if ({desc_rready_o, data_rready_o, tx_byte_valid_o, tx_byte_last_o, tx_end_o, tx_aborted_o, tx_byte_o, tx_count_o} !== '0)
            begin fails++; $display("FAIL rst_mid_send outputs got %0h want 0",
                {desc_rready_o, data_rready_o, tx_byte_valid_o, tx_byte_last_o, tx_end_o, tx_aborted_o, tx_byte_o, tx_count_o}); end
        rst_i = 1'b0;
        dq.delete();
        wq.delete();
        drive();
        tick();
        wq.push_back(32'h44332211);
        wq.push_back(32'h000000AA);
        run_xfer("after_rst", 5);
    endtask

    task automatic test_random();
        int len;
        rand_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 23);
            for (int i = 0; i < (len + Bpw - 1) / Bpw; i++) wq.push_back($urandom);
            run_xfer($sformatf("random_%0d_len%0d", t, len), len);
        end
        rand_ready = 1'b0;
        tx_byte_ready_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_depth_wait();
        test_abort_send();
        test_zero_len();
        test_hold_and_wait_abort();
        test_reset_mid_send();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached want finish before timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/descriptor_tx_unpack.md
Name: descriptor_tx_unpack

Overview:
- Next-generation TTI TX descriptor engine sitting between the TTI TX descriptor/data queues and the target FSM for Private Reads.
- Consumes full-width data words directly, with an internal word-to-byte unpacker replacing the external Nto8 converter.
- Data word width and length width are parametrised.
- Adds abort flush accounting, a transferred-byte count, an explicit aborted status and zero-length descriptor handling.

Parameters:
- DescDataWidth, 32, descriptor width; bits [LenWidth-1:0] carry the byte length.
- DataWidth, 32, data queue word width; a multiple of 8, from 8 to 64. BPW = DataWidth/8.
- LenWidth, 16, byte length field and counter width.
- DepthWidth, 16, data queue depth input width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- desc_rvalid_i  in  1  descriptor queue has an entry
- desc_rready_o  out  1  descriptor pop
- desc_rdata_i  in  DescDataWidth  descriptor
- data_rvalid_i  in  1  data queue has a word
- data_rready_o  out  1  data word pop
- data_rdata_i  in  DataWidth  data word
- data_depth_i  in  DepthWidth  words currently in the data queue
- tx_start_i  in  1  target FSM requests a transfer
- tx_abort_i  in  1  target FSM aborts (bus error / NACK)
- tx_desc_avail_o  out  1  equals desc_rvalid_i
- tx_byte_o  out  8  byte to the bus
- tx_byte_valid_o  out  1  tx_byte_o valid
- tx_byte_ready_i  in  1  FSM accepts the byte
- tx_byte_last_o  out  1  current byte is the final byte of the descriptor
- tx_end_o  out  1  one-cycle pulse: transfer finished (normally or aborted)
- tx_aborted_o  out  1  one-cycle pulse coincident with tx_end_o when the transfer ended via abort
- tx_count_o  out  LenWidth  bytes handshaked in the current or last transfer

Behaviour:
- Reset: FSM to IDLE. All outputs are 0 and internal counters/word register are cleared, except tx_desc_avail_o, which stays combinational from desc_rvalid_i. Reset mid-transfer drops all state; queues are not touched.
- FSM states: IDLE, WAIT, SEND, FLUSH.
- IDLE:
  - desc_rready_o = tx_start_i & desc_rvalid_i & !tx_abort_i.
  - On pop: latch len = desc_rdata_i[LenWidth-1:0]; words_left = ceil(len/BPW) (LenWidth arithmetic, no overflow for len up to 2^LenWidth-1); tx_count_o <= 0.
  - len==0: pulse tx_end_o next cycle and stay in IDLE; nothing is popped.
  - Otherwise go to WAIT.
- WAIT:
  - Go to SEND once data_depth_i >= words_left (zero-extended compare).
  - tx_abort_i: drop the descriptor, pulse tx_end_o and tx_aborted_o, go to IDLE; no data pop.
- SEND:
  - When no word is held and data_rvalid_i is high, assert data_rready_o for that cycle, load the word register, set byte_idx=0 and decrement words_left.
  - tx_byte_valid_o = word held. tx_byte_o = word[8*byte_idx +: 8] (little-endian).
  - On valid & ready: byte_idx++, remaining--, tx_count_o++. On byte_idx==BPW-1, or on the final byte, the word is released.
  - The next word may load in the same cycle the previous word is released (back-to-back bytes, no bubble).
  - tx_byte_last_o = valid & remaining==1.
  - Handshake of the last byte: pulse tx_end_o, go to IDLE. Unused trailing bytes of the final word are discarded.
  - tx_byte_o is held stable while valid & !ready.
- Abort in SEND:
  - Release the held word and go to FLUSH.
  - If abort and the last-byte handshake occur in the same cycle, normal completion wins and no aborted pulse is issued.
- FLUSH:
  - data_rready_o = data_rvalid_i while words_left>0; decrement per pop.
  - Exit when words_left==0 or data_rvalid_i==0: pulse tx_end_o and tx_aborted_o, go to IDLE.
- Latency: descriptor pop at cycle T; WAIT at T+1; SEND at T+2 earliest; first byte valid at T+3.
- tx_abort_i in IDLE is ignored. tx_start_i outside IDLE is ignored.

Optional Feature:
- DESCRIPTOR_TX_UNPACK_MSB_FIRST_EN defined: byte order within each word is MSB first, i.e. tx_byte_o = word[DataWidth-1-8*byte_idx -: 8].
- Undefined: little-endian order as described above.
- All other behaviour is identical.

Test Plan (DataWidth=32):
- len=5, queue words 0x44332211, 0x000000AA, depth 2, ready=1 -> bytes 11,22,33,44,AA back-to-back; last only on AA; 2 data pops; tx_end_o 1 cycle; tx_count_o=5.
- len=8, depth=1 for 10 cycles then 2 -> no tx_byte_valid_o while depth=1; first byte 3 cycles after depth reaches 2.
- len=12 (3 words), abort after 2 bytes -> 3 total data pops; tx_end_o and tx_aborted_o pulse together; tx_count_o=2; next descriptor starts cleanly.
- len=0 with tx_start_i -> 1 descriptor pop; tx_end_o pulses next cycle; no data pop; tx_aborted_o=0.
- Hold tx_byte_ready_i=0 for 3 cycles on byte 2 -> tx_byte_o=0x33 stable, no extra pop; abort during WAIT -> no data pop, aborted pulse.
- rst_i asserted mid-SEND -> next cycle: all outputs 0, FSM IDLE; new transfer then behaves as in the first scenario.
